// File: rtl/console_uart_tx_pkg.sv
// Shared definitions for the console peripheral: bus addresses, STATUS bit
// layout and TX FSM states (PARITY exists only when CONSOLE_PARITY_EN is defined).
package console_uart_tx_pkg;

    localparam logic [23:0] CON_STATUS_ADDR = 24'hFFFFFD;
    localparam logic [23:0] CON_STDOUT_ADDR = 24'hFFFFFE;
    localparam logic [23:0] CON_HALT_ADDR   = 24'hFFFFFF;

    localparam int unsigned ST_FULL  = 0;
    localparam int unsigned ST_EMPTY = 1;
    localparam int unsigned ST_BUSY  = 2;
    localparam int unsigned ST_OVF   = 3;
    localparam int unsigned ST_HALT  = 4;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef CONSOLE_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_e;

    function automatic logic [31:0] status_word(
        input logic halt,
        input logic ovf,
        input logic busy,
        input logic empty,
        input logic full
    );
        logic [31:0] w;
        w           = '0;
        w[ST_HALT]  = halt;
        w[ST_OVF]   = ovf;
        w[ST_BUSY]  = busy;
        w[ST_EMPTY] = empty;
        w[ST_FULL]  = full;
        return w;
    endfunction

endpackage

// File: rtl/console_uart_tx_fifo.sv
// console_fifo: small synchronous byte FIFO; wrap-around pointers carry one
// extra MSB so full and empty are distinguishable without a counter.
module console_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rstb,
    input  logic             i_clk_en,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign o_empty = (wr_ptr == rd_ptr);
    assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop frees the slot in the same cycle, so a push into a full FIFO is
    // accepted when a pop happens alongside it.
    assign do_pop  = i_pop & ~o_empty;
    assign do_push = i_push & (~o_full | do_pop);

    always_ff @(posedge i_clk) begin
        if (!i_rstb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (i_clk_en) begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_clk_en && do_push) mem[wr_ptr[AW-1:0]] <= i_data;
    end

    assign o_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/console_uart_tx.sv
// Memory-mapped console: STATUS/STDOUT/HALT decode, TX byte FIFO and UART
// serialiser. Define CONSOLE_PARITY_EN for 8E1 frames instead of 8N1.
module console_uart_tx
    import console_uart_tx_pkg::*;
#(
    parameter int unsigned BAUD_DIV   = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 24
) (
    input  logic              i_clk,
    input  logic              i_rstb,
    input  logic              i_clk_en,
    input  logic [ADDR_W-1:0] i_daddr,
    input  logic              i_wr,
    input  logic              i_rd,
    input  logic [31:0]       i_din,
    output logic [31:0]       o_dout,
    output logic              o_sel,
    output logic              o_txd,
    output logic              o_halt
);

    localparam int unsigned       BW        = $clog2(BAUD_DIV);
    localparam logic [BW-1:0]     BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0]     BAUD_ONE  = 1;
    localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(CON_STATUS_ADDR);
    localparam logic [ADDR_W-1:0] A_STDOUT  = ADDR_W'(CON_STDOUT_ADDR);
    localparam logic [ADDR_W-1:0] A_HALT    = ADDR_W'(CON_HALT_ADDR);
    localparam logic [2:0]        LAST_BIT  = 3'(DATA_BITS - 1);

    logic        is_status;
    logic        is_stdout;
    logic        is_halt;
    logic        push_req;
    logic        drop;
    logic        ovf;
    logic        busy;
    logic [31:0] rd_data;
    logic        unused_din;

    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;
    logic        tx_pop;

    tx_state_e   state, state_n;
    logic [BW-1:0] baud_cnt, baud_n;
    logic [2:0]  bit_cnt, bit_n;
    logic [7:0]  shreg, shreg_n;
    logic        txd_n;
`ifdef CONSOLE_PARITY_EN
    logic        par_bit, par_n;
`endif

    assign is_status  = (i_daddr == A_STATUS);
    assign is_stdout  = (i_daddr == A_STDOUT);
    assign is_halt    = (i_daddr == A_HALT);
    assign o_sel      = is_status | is_stdout | is_halt;
    assign unused_din = ^i_din[31:8];

    assign push_req = i_clk_en & i_wr & is_stdout;
    assign drop     = push_req & fifo_full & ~tx_pop;
    assign busy     = (state != TX_IDLE);

    console_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_rstb   (i_rstb),
        .i_clk_en (i_clk_en),
        .i_push   (push_req),
        .i_pop    (tx_pop),
        .i_data   (i_din[7:0]),
        .o_data   (fifo_dout),
        .o_full   (fifo_full),
        .o_empty  (fifo_empty)
    );

    always_comb begin
        rd_data = '0;
        if (is_status) rd_data = status_word(o_halt, ovf, busy, fifo_empty, fifo_full);
        else if (is_halt) rd_data = {31'b0, o_halt};
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstb) begin
            o_halt <= 1'b0;
            ovf    <= 1'b0;
            o_dout <= '0;
        end else if (i_clk_en) begin
            if (i_wr && is_halt) o_halt <= 1'b1;
            if (i_wr && is_status) ovf <= 1'b0;
            else if (drop)         ovf <= 1'b1;
            if (i_rd && o_sel) o_dout <= rd_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstb) begin
            state    <= TX_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            o_txd    <= 1'b1;
`ifdef CONSOLE_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else if (i_clk_en) begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            shreg    <= shreg_n;
            o_txd    <= txd_n;
`ifdef CONSOLE_PARITY_EN
            par_bit  <= par_n;
`endif
        end
    end

    // Frame start is shared by IDLE and end-of-STOP, so it is applied last as
    // an override; that keeps back-to-back frames free of an idle gap.
    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_cnt;
        shreg_n = shreg;
        txd_n   = o_txd;
        tx_pop  = 1'b0;
`ifdef CONSOLE_PARITY_EN
        par_n   = par_bit;
`endif
        if (state == TX_IDLE) begin
            tx_pop = ~fifo_empty;
        end else if (baud_cnt != '0) begin
            baud_n = baud_cnt - BAUD_ONE;
        end else begin
            baud_n = BAUD_LAST;
            case (state)
                TX_START: begin
                    state_n = TX_DATA;
                    txd_n   = shreg[0];
                    shreg_n = {1'b0, shreg[7:1]};
                    bit_n   = '0;
                end
                TX_DATA: begin
                    if (bit_cnt == LAST_BIT) begin
`ifdef CONSOLE_PARITY_EN
                        state_n = TX_PARITY;
                        txd_n   = par_bit;
`else
                        state_n = TX_STOP;
                        txd_n   = 1'b1;
`endif
                    end else begin
                        bit_n   = bit_cnt + 3'd1;
                        txd_n   = shreg[0];
                        shreg_n = {1'b0, shreg[7:1]};
                    end
                end
`ifdef CONSOLE_PARITY_EN
                TX_PARITY: begin
                    state_n = TX_STOP;
                    txd_n   = 1'b1;
                end
`endif
                TX_STOP: begin
                    if (fifo_empty) begin
                        state_n = TX_IDLE;
                        baud_n  = '0;
                        txd_n   = 1'b1;
                    end else begin
                        tx_pop = 1'b1;
                    end
                end
                default: begin
                    state_n = TX_IDLE;
                    baud_n  = '0;
                    txd_n   = 1'b1;
                end
            endcase
        end
        if (tx_pop) begin
            state_n = TX_START;
            baud_n  = BAUD_LAST;
            bit_n   = '0;
            shreg_n = fifo_dout;
            txd_n   = 1'b0;
`ifdef CONSOLE_PARITY_EN
            par_n   = ^fifo_dout;
`endif
        end
    end

endmodule

// File: tb/tb_console_uart_tx.sv
// Directed bench for console_uart_tx (BAUD_DIV=4, FIFO_DEPTH=4): a bus-access
// vector table plus hand-written serial sequences checked against a txd log.
module tb_console_uart_tx;

    localparam int BAUD = 4;
`ifdef CONSOLE_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_CYC = NBITS * BAUD;

    localparam logic [23:0] A_STATUS = 24'hFFFFFD;
    localparam logic [23:0] A_STDOUT = 24'hFFFFFE;
    localparam logic [23:0] A_HALT   = 24'hFFFFFF;

    logic        clk;
    logic        rstb;
    logic        clk_en;
    logic [23:0] daddr;
    logic        wr;
    logic        rd;
    logic [31:0] din;
    logic [31:0] dout;
    logic        sel;
    logic        txd;
    logic        halt;

    int n_checks = 0;
    int n_fail   = 0;

    logic rec = 1'b0;
    logic txlog [$];
    logic exp_q [$];

    typedef struct {
        string       name;
        logic        en;
        logic        wr;
        logic        rd;
        logic [23:0] addr;
        logic [31:0] din;
        logic        exp_sel;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t vecs [12];

    console_uart_tx #(
        .BAUD_DIV   (BAUD),
        .FIFO_DEPTH (4),
        .ADDR_W     (24)
    ) dut (
        .i_clk    (clk),
        .i_rstb   (rstb),
        .i_clk_en (clk_en),
        .i_daddr  (daddr),
        .i_wr     (wr),
        .i_rd     (rd),
        .i_din    (din),
        .o_dout   (dout),
        .o_sel    (sel),
        .o_txd    (txd),
        .o_halt   (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (rec) txlog.push_back(txd);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [23:0] a, input logic [31:0] d);
        daddr = a;
        din   = d;
        wr    = 1'b1;
        tick();
        wr    = 1'b0;
        din   = '0;
    endtask

    task automatic bus_read(input string name, input logic [23:0] a, input logic [31:0] exp);
        daddr = a;
        rd    = 1'b1;
        tick();
        rd    = 1'b0;
        chk(name, dout, exp);
    endtask

    task automatic exp_idle(input int n);
        repeat (n) exp_q.push_back(1'b1);
    endtask

    // Expected txd per cycle; hold_n extra copies follow sample hold_at (clock-enable stall).
    task automatic exp_frame(input logic [7:0] b, input int hold_at, input int hold_n);
        logic bits [NBITS];
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = b[i];
`ifdef CONSOLE_PARITY_EN
        bits[9] = ^b;
`endif
        bits[NBITS-1] = 1'b1;
        for (int c = 0; c < FRAME_CYC; c++) begin
            exp_q.push_back(bits[c / BAUD]);
            if (c == hold_at) repeat (hold_n) exp_q.push_back(bits[c / BAUD]);
        end
    endtask

    task automatic run_until(input int n);
        for (int i = 0; i < 2 * n + 100; i++) begin
            if (txlog.size() >= n) break;
            tick();
        end
    endtask

    task automatic chk_log(input string name);
        int   bad;
        logic act_v;
        logic exp_v;
        bad = -1;
        n_checks++;
        for (int i = 0; i < exp_q.size(); i++)
            if (bad < 0 && (i >= txlog.size() || txlog[i] !== exp_q[i])) bad = i;
        if (bad < 0 && txlog.size() != exp_q.size()) bad = exp_q.size();
        if (bad >= 0) begin
            n_fail++;
            act_v = (bad < txlog.size()) ? txlog[bad] : 1'bz;
            exp_v = (bad < exp_q.size()) ? exp_q[bad] : 1'bz;
            $display("FAIL %s: txd sample %0d got %b required %b (captured %0d samples, required %0d)",
                     name, bad, act_v, exp_v, txlog.size(), exp_q.size());
        end
        txlog.delete();
        exp_q.delete();
    endtask

    initial begin
        vecs[0]  = '{"rd_halt_idle",    1'b1, 1'b0, 1'b1, 24'hFFFFFF, 32'h0,        1'b1, 32'h0};
        vecs[1]  = '{"rd_status_idle",  1'b1, 1'b0, 1'b1, 24'hFFFFFD, 32'h0,        1'b1, 32'h2};
        vecs[2]  = '{"rd_unmapped",     1'b1, 1'b0, 1'b1, 24'hFFFFFC, 32'h0,        1'b0, 32'h2};
        vecs[3]  = '{"wr_unmapped",     1'b1, 1'b1, 1'b0, 24'hFFFFFC, 32'h41,       1'b0, 32'h2};
        vecs[4]  = '{"rd_low_addr",     1'b1, 1'b0, 1'b1, 24'h000000, 32'h0,        1'b0, 32'h2};
        vecs[5]  = '{"rd_stdout_zero",  1'b1, 1'b0, 1'b1, 24'hFFFFFE, 32'h0,        1'b1, 32'h0};
        vecs[6]  = '{"rd_status_noen",  1'b0, 1'b0, 1'b1, 24'hFFFFFD, 32'h0,        1'b1, 32'h0};
        vecs[7]  = '{"wr_stdout_noen",  1'b0, 1'b1, 1'b0, 24'hFFFFFE, 32'h5A,       1'b1, 32'h0};
        vecs[8]  = '{"wr_halt_noen",    1'b0, 1'b1, 1'b0, 24'hFFFFFF, 32'h1,        1'b1, 32'h0};
        vecs[9]  = '{"rd_status_after", 1'b1, 1'b0, 1'b1, 24'hFFFFFD, 32'h0,        1'b1, 32'h2};
        vecs[10] = '{"wr_status",       1'b1, 1'b1, 1'b0, 24'hFFFFFD, 32'hFFFFFFFF, 1'b1, 32'h2};
        vecs[11] = '{"rd_halt_after",   1'b1, 1'b0, 1'b1, 24'hFFFFFF, 32'h0,        1'b1, 32'h0};

        rstb = 1'b0; clk_en = 1'b1; daddr = '0; wr = 1'b0; rd = 1'b0; din = '0;
        repeat (3) tick();
        chk("reset_txd",  {31'b0, txd},  32'h1);
        chk("reset_halt", {31'b0, halt}, 32'h0);
        chk("reset_dout", dout,          32'h0);
        chk("reset_sel_low_addr", {31'b0, sel}, 32'h0);
        rstb = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            clk_en = vecs[i].en;
            wr     = vecs[i].wr;
            rd     = vecs[i].rd;
            daddr  = vecs[i].addr;
            din    = vecs[i].din;
            #1;
            chk({vecs[i].name, "_sel"}, {31'b0, sel}, {31'b0, vecs[i].exp_sel});
            tick();
            wr = 1'b0; rd = 1'b0; clk_en = 1'b1; din = '0;
            chk({vecs[i].name, "_dout"}, dout, vecs[i].exp_dout);
        end
        chk("table_halt", {31'b0, halt}, 32'h0);
        chk("table_txd",  {31'b0, txd},  32'h1);

        // Single byte: exact frame, busy clears on the cycle after the stop bit.
        exp_idle(2); exp_frame(8'h41, -1, 0); exp_idle(1);
        rec = 1'b1;
        bus_write(A_STDOUT, 32'h41);
        repeat (FRAME_CYC) tick();
        bus_read("t1_status_busy_end", A_STATUS, 32'h06);
        bus_read("t1_status_idle",     A_STATUS, 32'h02);
        rec = 1'b0;
        chk_log("t1_frame_41");

        // Six back-to-back stores: one in flight, four buffered, one dropped.
        exp_idle(2);
        for (int i = 0; i < 5; i++) exp_frame(8'(8'h30 + i), -1, 0);
        exp_idle(1);
        rec = 1'b1;
        for (int i = 0; i < 6; i++) bus_write(A_STDOUT, 32'h30 + i);
        bus_read("t2_status_full_ovf", A_STATUS, 32'h0D);
        run_until(2 + 5 * FRAME_CYC + 1);
        rec = 1'b0;
        chk_log("t2_five_frames");
        bus_read("t2_status_ovf_sticky", A_STATUS, 32'h0A);
        bus_write(A_STATUS, 32'h0);
        bus_read("t2_status_ovf_cleared", A_STATUS, 32'h02);

        // Two queued bytes (parity 0 and 1 when parity is enabled).
        exp_idle(2); exp_frame(8'h41, -1, 0); exp_frame(8'h43, -1, 0); exp_idle(1);
        rec = 1'b1;
        bus_write(A_STDOUT, 32'h41);
        bus_write(A_STDOUT, 32'h43);
        run_until(2 + 2 * FRAME_CYC + 1);
        rec = 1'b0;
        chk_log("t6_frames_41_43");

        // Clock enable low for 7 cycles during data bit 1.
        exp_idle(2); exp_frame(8'hA6, 9, 7); exp_idle(1);
        rec = 1'b1;
        bus_write(A_STDOUT, 32'hA6);
        repeat (10) tick();
        clk_en = 1'b0;
        repeat (7) tick();
        clk_en = 1'b1;
        run_until(2 + FRAME_CYC + 7 + 1);
        rec = 1'b0;
        chk_log("t4_stall_frame");

        // HALT is sticky.
        chk("t3_halt_before", {31'b0, halt}, 32'h0);
        bus_write(A_HALT, 32'h0);
        chk("t3_halt_set", {31'b0, halt}, 32'h1);
        bus_read("t3_rd_halt",   A_HALT,   32'h1);
        bus_read("t3_rd_status", A_STATUS, 32'h12);
        bus_write(A_STATUS, 32'h0);
        repeat (5) tick();
        chk("t3_halt_sticky", {31'b0, halt}, 32'h1);

        // Reset during data bit 3 of 0x55 with 0x66 still queued.
        bus_write(A_STDOUT, 32'h55);
        bus_write(A_STDOUT, 32'h66);
        repeat (17) tick();
        chk("t5_txd_bit3", {31'b0, txd}, 32'h0);
        rstb = 1'b0;
        tick();
        rstb = 1'b1;
        chk("t5_txd_after_rst",  {31'b0, txd},  32'h1);
        chk("t5_halt_after_rst", {31'b0, halt}, 32'h0);
        chk("t5_dout_after_rst", dout,          32'h0);
        exp_idle(12);
        rec = 1'b1;
        bus_read("t5_status_after_rst", A_STATUS, 32'h02);
        repeat (11) tick();
        rec = 1'b0;
        chk_log("t5_line_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
